// File: rtl/rr_grant_encoder_if.sv
// Request/grant bundle between the requesters, the round-robin encoder and
// the downstream 3-to-8 decode stage.
interface rr_grant_encoder_if;
  logic [7:0] req;
  logic       ack;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic       timeout;

  modport master (
    output req,
    output ack,
    input  grant_idx,
    input  grant_valid,
    input  timeout
  );

  modport slave (
    input  req,
    input  ack,
    output grant_idx,
    output grant_valid,
    output timeout
  );
endinterface

// File: rtl/rr_grant_encoder.sv
// Round-robin arbiter over 8 requesters producing a binary grant index,
// held until ack or abandoned after TIMEOUT cycles.
//
//   state | meaning
//   IDLE  | no grant outstanding; search from ptr on the next edge
//   GRANT | grant_idx/grant_valid held, waiting for ack or timeout
module rr_grant_encoder #(
  parameter int TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            reset,
  rr_grant_encoder_if.slave bus
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state_q, state_d;
  logic [2:0]    ptr_q, ptr_d;
  logic [2:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          to_q, to_d;

  logic          hit;
  logic [2:0]    pick;
  logic [2:0]    cand;

  // Wrap-around search: first set request at ptr, ptr+1, ... ptr+7.
  always_comb begin
    hit  = 1'b0;
    pick = ptr_q;
    cand = ptr_q;
    for (int k = 0; k < 8; k++) begin
      cand = ptr_q + 3'(k);
      if (!hit && bus.req[cand]) begin
        hit  = 1'b1;
        pick = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    to_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (hit) begin
          idx_d   = pick;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // ack wins over an expiring counter on the same edge
        if (bus.ack) begin
          ptr_d   = idx_q + 3'd1;
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          ptr_d   = idx_q + 3'd1;
          to_d    = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end

  // grant_valid decodes the state register so reset drops it without a clock edge
  assign bus.grant_idx   = idx_q;
  assign bus.grant_valid = (state_q == GRANT);
  assign bus.timeout     = to_q;

endmodule

// File: tb/tb_rr_grant_encoder.sv
// Directed bench for rr_grant_encoder: rotation, back-to-back grants,
// timeout abandon, ack/timeout collision, req drop and mid-grant reset.
module tb_rr_grant_encoder;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  rr_grant_encoder_if bus ();

  rr_grant_encoder #(.TIMEOUT(15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.req = 8'h00;
    bus.ack = 1'b0;
    reset   = 1'b1;
    #3;
    reset   = 1'b0;
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    bus.req = 8'hFF;
    bus.ack = 1'b0;
    repeat (3) tick();
    n_checks++; if (bus.grant_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.grant_valid); end
    n_checks++; if (bus.grant_idx !== 3'd0) begin n_fail++; $display("FAIL reset_idx: got %0d expected 0", bus.grant_idx); end
    n_checks++; if (bus.timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b expected 0", bus.timeout); end
    bus.req = 8'h00;
    reset   = 1'b0;
    tick();
    n_checks++; if (bus.grant_valid !== 1'b0) begin n_fail++; $display("FAIL idle_no_req: got %b expected 0", bus.grant_valid); end
  endtask

  task automatic test_rotation();
    do_reset();
    bus.req = 8'b1000_0100;
    tick();
    n_checks++; if (bus.grant_valid !== 1'b1 || bus.grant_idx !== 3'd2) begin n_fail++; $display("FAIL rot_first: got v=%b idx=%0d expected v=1 idx=2", bus.grant_valid, bus.grant_idx); end
    bus.ack = 1'b1;
    tick();
    n_checks++; if (bus.grant_valid !== 1'b0) begin n_fail++; $display("FAIL rot_idle1: got %b expected 0", bus.grant_valid); end
    bus.ack = 1'b0;
    tick();
    n_checks++; if (bus.grant_valid !== 1'b1 || bus.grant_idx !== 3'd7) begin n_fail++; $display("FAIL rot_second: got v=%b idx=%0d expected v=1 idx=7", bus.grant_valid, bus.grant_idx); end
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    tick();
    n_checks++; if (bus.grant_valid !== 1'b1 || bus.grant_idx !== 3'd2) begin n_fail++; $display("FAIL rot_third: got v=%b idx=%0d expected v=1 idx=2", bus.grant_valid, bus.grant_idx); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.req = 8'hFF;
    bus.ack = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      n_checks++; if (bus.grant_valid !== 1'b1 || bus.grant_idx !== 3'(i % 8)) begin n_fail++; $display("FAIL b2b_grant[%0d]: got v=%b idx=%0d expected v=1 idx=%0d", i, bus.grant_valid, bus.grant_idx, i % 8); end
      tick();
      n_checks++; if (bus.grant_valid !== 1'b0 || bus.timeout !== 1'b0) begin n_fail++; $display("FAIL b2b_idle[%0d]: got v=%b to=%b expected v=0 to=0", i, bus.grant_valid, bus.timeout); end
    end
    bus.ack = 1'b0;
  endtask

  task automatic test_timeout();
    do_reset();
    bus.req = 8'b0000_0001;
    tick();
    n_checks++; if (bus.grant_valid !== 1'b1 || bus.grant_idx !== 3'd0) begin n_fail++; $display("FAIL to_grant: got v=%b idx=%0d expected v=1 idx=0", bus.grant_valid, bus.grant_idx); end
    for (int k = 1; k < 15; k++) begin
      tick();
      n_checks++; if (bus.grant_valid !== 1'b1 || bus.timeout !== 1'b0) begin n_fail++; $display("FAIL to_hold[%0d]: got v=%b to=%b expected v=1 to=0", k, bus.grant_valid, bus.timeout); end
    end
    tick();
    n_checks++; if (bus.grant_valid !== 1'b0 || bus.timeout !== 1'b1) begin n_fail++; $display("FAIL to_abandon: got v=%b to=%b expected v=0 to=1", bus.grant_valid, bus.timeout); end
    tick();
    n_checks++; if (bus.grant_valid !== 1'b1 || bus.grant_idx !== 3'd0 || bus.timeout !== 1'b0) begin n_fail++; $display("FAIL to_regrant: got v=%b idx=%0d to=%b expected v=1 idx=0 to=0", bus.grant_valid, bus.grant_idx, bus.timeout); end
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
  endtask

  task automatic test_ack_at_limit();
    do_reset();
    bus.req = 8'b0000_0011;
    tick();
    n_checks++; if (bus.grant_idx !== 3'd0) begin n_fail++; $display("FAIL lim_grant: got idx=%0d expected 0", bus.grant_idx); end
    repeat (14) tick();
    bus.ack = 1'b1;
    tick();
    n_checks++; if (bus.grant_valid !== 1'b0 || bus.timeout !== 1'b0) begin n_fail++; $display("FAIL lim_ack_wins: got v=%b to=%b expected v=0 to=0", bus.grant_valid, bus.timeout); end
    bus.ack = 1'b0;
    tick();
    n_checks++; if (bus.grant_valid !== 1'b1 || bus.grant_idx !== 3'd1 || bus.timeout !== 1'b0) begin n_fail++; $display("FAIL lim_ptr_adv: got v=%b idx=%0d to=%b expected v=1 idx=1 to=0", bus.grant_valid, bus.grant_idx, bus.timeout); end
  endtask

  task automatic test_req_drop();
    do_reset();
    bus.req = 8'b0001_0000;
    tick();
    bus.req = 8'h00;
    repeat (3) tick();
    n_checks++; if (bus.grant_valid !== 1'b1 || bus.grant_idx !== 3'd4) begin n_fail++; $display("FAIL drop_hold: got v=%b idx=%0d expected v=1 idx=4", bus.grant_valid, bus.grant_idx); end
    bus.req = 8'hFF;
    repeat (2) tick();
    n_checks++; if (bus.grant_valid !== 1'b1 || bus.grant_idx !== 3'd4) begin n_fail++; $display("FAIL drop_reqchg: got v=%b idx=%0d expected v=1 idx=4", bus.grant_valid, bus.grant_idx); end
    bus.req = 8'h00;
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    repeat (2) tick();
    n_checks++; if (bus.grant_valid !== 1'b0 || bus.grant_idx !== 3'd4) begin n_fail++; $display("FAIL drop_idle: got v=%b idx=%0d expected v=0 idx=4", bus.grant_valid, bus.grant_idx); end
  endtask

  task automatic test_single_requester();
    do_reset();
    bus.req = 8'b0100_0000;
    bus.ack = 1'b1;
    tick();
    n_checks++; if (bus.grant_idx !== 3'd6 || bus.grant_valid !== 1'b1) begin n_fail++; $display("FAIL single_first: got v=%b idx=%0d expected v=1 idx=6", bus.grant_valid, bus.grant_idx); end
    repeat (2) tick();
    n_checks++; if (bus.grant_idx !== 3'd6 || bus.grant_valid !== 1'b1) begin n_fail++; $display("FAIL single_again: got v=%b idx=%0d expected v=1 idx=6", bus.grant_valid, bus.grant_idx); end
    bus.ack = 1'b0;
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    bus.req = 8'b0000_0100;
    tick();
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    bus.req = 8'b0010_0000;
    tick();
    n_checks++; if (bus.grant_valid !== 1'b1 || bus.grant_idx !== 3'd5) begin n_fail++; $display("FAIL mid_setup: got v=%b idx=%0d expected v=1 idx=5", bus.grant_valid, bus.grant_idx); end
    #1;
    reset = 1'b1;
    #1;
    n_checks++; if (bus.grant_valid !== 1'b0 || bus.grant_idx !== 3'd0) begin n_fail++; $display("FAIL mid_async: got v=%b idx=%0d expected v=0 idx=0", bus.grant_valid, bus.grant_idx); end
    #1;
    reset   = 1'b0;
    bus.req = 8'b0010_0010;
    tick();
    n_checks++; if (bus.grant_valid !== 1'b1 || bus.grant_idx !== 3'd1) begin n_fail++; $display("FAIL mid_ptr0: got v=%b idx=%0d expected v=1 idx=1", bus.grant_valid, bus.grant_idx); end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_back_to_back();
    test_timeout();
    test_ack_at_limit();
    test_req_drop();
    test_single_requester();
    test_reset_mid_grant();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
